// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the CPU path (A) and a DMA/debug loader (B).
// Build with DMEM_ARB_ADDR_CHECK_EN defined to add address range/alignment checking and a sticky err output.

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_LOCK  = 16,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    // state     | meaning
    // ST_ARB    | round-robin between A and B, prio_b_q says who wins a tie
    // ST_LOCK_B | B owns the port; A is held off until b_lock drops or the lock budget runs out

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCK_B = 1'b1
    } state_e;

    localparam int LOCK_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    if (MAX_LOCK < 1 || MEM_WORDS < 1) begin : g_bad_params
        $error("dmem_arbiter: MAX_LOCK and MEM_WORDS must both be at least 1");
    end

    state_e              state_q, state_d;
    logic                prio_b_q, prio_b_d;
    logic [LOCK_W-1:0]   lock_left_q, lock_left_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [DATA_W-1:0]   last_wdata_q, last_wdata_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                err_q, err_d;

    logic                a_gnt_c, b_gnt_c, any_gnt;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                addr_err;
    logic [DATA_W-1:0]   rd_value;

    always_comb begin
        a_gnt_c = 1'b0;
        b_gnt_c = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCK_B) begin
                b_gnt_c = b_req;
            end else if (a_req && b_req) begin
                a_gnt_c = ~prio_b_q;
                b_gnt_c = prio_b_q;
            end else begin
                a_gnt_c = a_req;
                b_gnt_c = b_req;
            end
        end
    end

    assign any_gnt   = a_gnt_c | b_gnt_c;
    assign win_we    = b_gnt_c ? b_we    : a_we;
    assign win_addr  = b_gnt_c ? b_addr  : a_addr;
    assign win_wdata = b_gnt_c ? b_wdata : a_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign addr_err = any_gnt &&
                      (((win_addr >> 2) >= ADDR_W'(MEM_WORDS)) || (win_addr[1:0] != 2'b00));
`else
    assign addr_err = 1'b0;
`endif

    // A faulting access keeps its grant slot but never reaches the memory.
    assign mem_read  = any_gnt & ~win_we & ~addr_err;
    assign mem_write = any_gnt &  win_we & ~addr_err;
    assign mem_addr  = rst ? '0 : (any_gnt ? win_addr  : last_addr_q);
    assign mem_wdata = rst ? '0 : (any_gnt ? win_wdata : last_wdata_q);

    assign rd_value  = addr_err ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        prio_b_d    = prio_b_q;
        lock_left_d = lock_left_q;

        case (state_q)
            ST_ARB: begin
                if (a_gnt_c) prio_b_d = 1'b1;
                if (b_gnt_c) prio_b_d = 1'b0;
                if (b_gnt_c && b_lock) begin
                    state_d     = ST_LOCK_B;
                    lock_left_d = LOCK_W'(MAX_LOCK - 1);
                end
            end
            ST_LOCK_B: begin
                if (!b_lock) begin
                    state_d     = ST_ARB;
                    prio_b_d    = 1'b0;
                    lock_left_d = '0;
                end else if (b_gnt_c) begin
                    // Terminal count: this grant is the last one the lock may take.
                    if (lock_left_q == '0) begin
                        state_d  = ST_ARB;
                        prio_b_d = 1'b0;
                    end else begin
                        lock_left_d = lock_left_q - LOCK_W'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_ARB;
                prio_b_d    = 1'b0;
                lock_left_d = '0;
            end
        endcase
    end

    always_comb begin
        last_addr_d  = any_gnt ? win_addr  : last_addr_q;
        last_wdata_d = any_gnt ? win_wdata : last_wdata_q;

        a_rvalid_d = a_gnt_c & ~a_we;
        b_rvalid_d = b_gnt_c & ~b_we;
        a_rdata_d  = a_rvalid_d ? rd_value : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? rd_value : b_rdata_q;

        err_d = err_q | addr_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ARB;
            prio_b_q     <= 1'b0;
            lock_left_q  <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_b_q     <= prio_b_d;
            lock_left_q  <= lock_left_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            err_q        <= err_d;
        end
    end

    assign a_gnt    = a_gnt_c;
    assign b_gnt    = b_gnt_c;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign err = err_q;
`endif

endmodule
